// File: rtl/iq_sink.sv
// iq_sink: capture sink for the interpolator streaming path.
// Pops I/Q samples from the upstream output FIFO (read-enable / empty handshake)
// and stores them into an internal dual-word memory, readable through a
// registered address port. Exports a status word and a one-cycle done pulse.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         start pulse, honoured only in IDLE
//   stop_i          ends continuous capture (mode 01 only)
//   config_reg      [7:0] depth N, [15:8] offset, [17:16] mode; latched on start
//   empty_i         upstream FIFO empty
//   I_i, Q_i        FIFO read data, valid the cycle after RE_fifo_o
//   RE_fifo_o       FIFO read enable
//   rd_addr_i       memory read address
//   I_o, Q_o        registered memory read data (1-cycle latency)
//   status_reg      [0] busy, [1] done (sticky), [2] wrapped, [15:8] stored count
//   done_o          one-cycle completion pulse
//
// state   | meaning
// IDLE    | waiting for start_i
// CAPTURE | issuing FIFO reads while more are required
// DRAIN   | last in-flight sample being stored
// DONE    | done_o pulse, then back to IDLE
module iq_sink #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE_M = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic [31:0]           config_reg,
   input  logic                  empty_i,
   input  logic [DATA_WIDTH-1:0] I_i,
   input  logic [DATA_WIDTH-1:0] Q_i,
   output logic                  RE_fifo_o,
   input  logic [MEM_SIZE_M-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] I_o,
   output logic [DATA_WIDTH-1:0] Q_o,
   output logic [31:0]           status_reg,
   output logic                  done_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   logic [1:0]  state;
   logic [7:0]  cfg_n;
   logic [7:0]  cfg_off;
   logic [1:0]  cfg_mode;
   logic [8:0]  reads_left;
   logic        vld;
   logic        dec_skip;
   logic [7:0]  idx;
   logic [7:0]  count;
   logic        busy;
   logic        done_bit;
   logic        wrapped;

   logic        mode_cont;
   logic        mode_dec;
   logic        re;
   logic        capture_end;
   logic        store;
   logic [MEM_SIZE_M-1:0] wr_addr;

   logic [2*DATA_WIDTH-1:0] mem [2**MEM_SIZE_M];

   logic unused_cfg;
   assign unused_cfg = ^config_reg[31:18];

   assign mode_cont = (cfg_mode == 2'b01);
   assign mode_dec  = (cfg_mode == 2'b10);

   always_comb begin
      re          = 1'b0;
      capture_end = 1'b0;
      if (state == ST_CAPTURE) begin
         if (mode_cont) begin
            // continuous with N = 0 only waits for stop, never reads
            re          = !empty_i && !stop_i && (cfg_n != 8'd0);
            capture_end = stop_i;
         end else begin
            re          = !empty_i && (reads_left != 9'd0);
            capture_end = (reads_left == 9'd0) || (re && reads_left == 9'd1);
         end
      end
   end

   // in decimate mode every second arriving sample is dropped
   assign store   = vld && !dec_skip;
   assign wr_addr = MEM_SIZE_M'(cfg_off) + MEM_SIZE_M'(idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cfg_n      <= '0;
         cfg_off    <= '0;
         cfg_mode   <= '0;
         reads_left <= '0;
         vld        <= 1'b0;
         dec_skip   <= 1'b0;
         idx        <= '0;
         count      <= '0;
         busy       <= 1'b0;
         done_bit   <= 1'b0;
         wrapped    <= 1'b0;
      end else begin
         vld <= re;
         if (vld) begin
            dec_skip <= mode_dec ? !dec_skip : 1'b0;
         end
         if (store) begin
            if (count != 8'hFF) begin
               count <= count + 8'd1;
            end
            if (mode_cont && idx == cfg_n - 8'd1) begin
               idx     <= '0;
               wrapped <= 1'b1;
            end else begin
               idx <= idx + 8'd1;
            end
         end
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  cfg_n      <= config_reg[7:0];
                  cfg_off    <= config_reg[15:8];
                  cfg_mode   <= config_reg[17:16];
                  reads_left <= (config_reg[17:16] == 2'b10) ? {config_reg[7:0], 1'b0}
                                                             : {1'b0, config_reg[7:0]};
                  idx        <= '0;
                  count      <= '0;
                  dec_skip   <= 1'b0;
                  wrapped    <= 1'b0;
                  done_bit   <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (re && !mode_cont) begin
                  reads_left <= reads_left - 9'd1;
               end
               if (capture_end) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // the read pipeline is one deep, so one cycle always suffices
               state    <= ST_DONE;
               busy     <= 1'b0;
               done_bit <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && store) begin
         mem[wr_addr] <= {I_i, Q_i};
      end
   end

   // same-address read during a write returns the old word
   always_ff @(posedge clk) begin
      if (rst) begin
         I_o <= '0;
         Q_o <= '0;
      end else begin
         {I_o, Q_o} <= mem[rd_addr_i];
      end
   end

   assign RE_fifo_o  = re;
   assign done_o     = (state == ST_DONE);
   assign status_reg = {16'h0000, count, 5'b00000, wrapped, done_bit, busy};

endmodule

// File: tb/tb_iq_sink.sv
module tb_iq_sink;
   localparam int DW = 32;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          stop_i;
   logic [31:0]   config_reg;
   logic          empty_i;
   logic [DW-1:0] I_i;
   logic [DW-1:0] Q_i;
   logic          RE_fifo_o;
   logic [AW-1:0] rd_addr_i;
   logic [DW-1:0] I_o;
   logic [DW-1:0] Q_o;
   logic [31:0]   status_reg;
   logic          done_o;

   always #5 clk = ~clk;

   iq_sink #(.DATA_WIDTH(DW), .MEM_SIZE_M(AW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
      .config_reg(config_reg), .empty_i(empty_i), .I_i(I_i), .Q_i(Q_i),
      .RE_fifo_o(RE_fifo_o), .rd_addr_i(rd_addr_i), .I_o(I_o), .Q_o(Q_o),
      .status_reg(status_reg), .done_o(done_o)
   );

   typedef struct {
      int done_rel;
      int n_re;
      int first_re;
      int last_re;
      int count;
      bit wrapped;
   } done_exp_t;

   done_exp_t   done_q[$];
   logic [63:0] rd_q[$];
   logic [31:0] feed_i[$];
   logic [31:0] feed_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int t0 = -1000;
   int re_cnt = 0;
   int re_base = 0;
   int re_first = 0;
   int re_last = 0;
   int done_seen = 0;
   int fed = 0;
   logic [31:0] stall = '0;
   bit rd_req = 1'b0;
   bit rd_stage = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc - t0);
      end
   endtask

   function automatic done_exp_t mk(int d, int n, int f, int l, int c, bit w);
      done_exp_t e;
      e.done_rel = d; e.n_re = n; e.first_re = f; e.last_re = l; e.count = c; e.wrapped = w;
      return e;
   endfunction

   // one cycle: drive FIFO data for the previous read and empty_i for the new cycle
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (re_cnt > fed) begin
         fed++;
         I_i = (feed_i.size() > 0) ? feed_i.pop_front() : 32'hDEAD;
         Q_i = (feed_q.size() > 0) ? feed_q.pop_front() : 32'hBEEF;
      end
      empty_i = (cyc - t0 >= 0 && cyc - t0 < 32) ? stall[cyc - t0] : 1'b0;
   endtask

   task automatic feed(input int i, input int q);
      feed_i.push_back(i);
      feed_q.push_back(q);
   endtask

   task automatic rd_chk(input logic [AW-1:0] a, input int i, input int q);
      rd_addr_i = a;
      rd_req    = 1'b1;
      rd_q.push_back({i[31:0], q[31:0]});
      step();
      rd_req = 1'b0;
   endtask

   always @(posedge clk) rd_stage <= rd_req;

   // monitor / scoreboard
   always @(negedge clk) begin
      done_exp_t e;
      logic [63:0] r;
      if (RE_fifo_o === 1'b1) begin
         chk("re_vs_empty", empty_i, 0);
         if (re_cnt == re_base) re_first = cyc;
         re_last = cyc;
         re_cnt++;
      end
      if (done_o === 1'b1) begin
         done_seen++;
         if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done_o=1 at cycle %0d, required 0", cyc - t0);
         end else begin
            e = done_q.pop_front();
            chk("done_cycle", cyc - t0, e.done_rel);
            chk("re_count", re_cnt - re_base, e.n_re);
            if (e.n_re > 0) begin
               chk("first_re", re_first - t0, e.first_re);
               chk("last_re", re_last - t0, e.last_re);
            end
            chk("status_busy", status_reg[0], 0);
            chk("status_done", status_reg[1], 1);
            chk("status_wrapped", status_reg[2], e.wrapped);
            chk("status_count", status_reg[15:8], e.count);
         end
      end
      if (rd_stage) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_underflow: read result with no expectation queued");
         end else begin
            r = rd_q.pop_front();
            chk("mem_I", I_o, r[63:32]);
            chk("mem_Q", Q_o, r[31:0]);
         end
      end
   end

   task automatic run(input logic [31:0] cfg, input logic [31:0] stall_m,
                      input int stop_rel, input int mid_rel, input int rd_rel,
                      input logic [AW-1:0] rd_a, input logic [63:0] rd_e,
                      input done_exp_t e);
      int prev;
      stall      = stall_m;
      config_reg = cfg;
      start_i    = 1'b1;
      t0         = cyc;
      re_base    = re_cnt;
      done_q.push_back(e);
      prev = done_seen;
      step();
      start_i    = 1'b0;
      config_reg = ~cfg;
      chk("status_cycle1", status_reg[15:0], 16'h0001);
      for (int k = 0; k < 64 && done_seen == prev; k++) begin
         stop_i = (cyc - t0 == stop_rel);
         if (cyc - t0 == mid_rel) begin
            start_i    = 1'b1;
            config_reg = 32'h0000_0007;
         end else begin
            start_i = 1'b0;
         end
         if (cyc - t0 == rd_rel) begin
            rd_addr_i = rd_a;
            rd_req    = 1'b1;
            rd_q.push_back(rd_e);
         end else begin
            rd_req = 1'b0;
         end
         step();
      end
      chk("done_seen", done_seen - prev, 1);
      stop_i  = 1'b0;
      start_i = 1'b0;
      rd_req  = 1'b0;
      stall   = '0;
      step();
      step();
      chk("status_after", status_reg[1:0], 2);
      feed_i.delete();
      feed_q.delete();
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; empty_i = 1'b0;
      config_reg = '0; rd_addr_i = '0; I_i = '0; Q_i = '0;
      repeat (3) step();
      chk("rst_RE", RE_fifo_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_status", status_reg, 0);
      chk("rst_I", I_o, 0);
      chk("rst_Q", Q_o, 0);
      rst = 1'b0;
      step();

      // one-shot N=4 offset 0
      for (int i = 1; i <= 4; i++) feed(i, 100 + i);
      run(32'h0000_0004, 32'h0, -1, -1, -1, '0, '0, mk(6, 4, 1, 4, 4, 1'b0));
      for (int i = 0; i < 4; i++) rd_chk(AW'(i), i + 1, 101 + i);
      step();

      // reset mid-traffic, address 0 holds (1,101) so I_o/Q_o are nonzero beforehand
      for (int i = 31; i <= 40; i++) feed(i, 100 + i);
      rd_addr_i  = '0;
      config_reg = 32'h0000_500A;
      start_i    = 1'b1;
      t0         = cyc;
      re_base    = re_cnt;
      step();
      start_i = 1'b0;
      step();
      step();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("midrst_RE", RE_fifo_o, 0);
         chk("midrst_done", done_o, 0);
         chk("midrst_status", status_reg, 0);
         chk("midrst_I", I_o, 0);
         chk("midrst_Q", Q_o, 0);
      end
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("postrst_empty", empty_i, 0);
         chk("postrst_RE", RE_fifo_o, 0);
      end
      feed_i.delete();
      feed_q.delete();

      // stall: empty on cycles 2 and 3, offset 8
      for (int i = 1; i <= 4; i++) feed(i, 100 + i);
      run(32'h0000_0804, 32'h0000_000C, -1, -1, -1, '0, '0, mk(8, 4, 1, 6, 4, 1'b0));
      for (int i = 0; i < 4; i++) rd_chk(AW'(8 + i), i + 1, 101 + i);
      step();

      // address wrap: offset 126
      for (int i = 21; i <= 24; i++) feed(i, 100 + i);
      run(32'h0000_7E04, 32'h0, -1, -1, -1, '0, '0, mk(6, 4, 1, 4, 4, 1'b0));
      rd_chk(7'd126, 21, 121);
      rd_chk(7'd127, 22, 122);
      rd_chk(7'd0, 23, 123);
      rd_chk(7'd1, 24, 124);
      step();

      // decimate-by-2: N=3 offset 20
      for (int i = 10; i <= 15; i++) feed(i, 100 + i);
      run(32'h0002_1403, 32'h0, -1, -1, -1, '0, '0, mk(8, 6, 1, 6, 3, 1'b0));
      rd_chk(7'd20, 10, 110);
      rd_chk(7'd21, 12, 112);
      rd_chk(7'd22, 14, 114);
      step();

      // continuous: N=2 offset 40, stop in cycle 6, ignored start+config change in cycle 3
      for (int i = 51; i <= 55; i++) feed(i, 100 + i);
      run(32'h0001_2802, 32'h0, 6, 3, -1, '0, '0, mk(8, 5, 1, 5, 5, 1'b1));
      rd_chk(7'd40, 55, 155);
      rd_chk(7'd41, 54, 154);
      step();

      // N=0 one-shot: no reads
      run(32'h0000_0000, 32'h0, -1, -1, -1, '0, '0, mk(3, 0, 0, 0, 0, 1'b0));

      // mode 11 behaves as one-shot: N=2 offset 48
      feed(61, 161); feed(62, 162);
      run(32'h0003_3002, 32'h0, -1, -1, -1, '0, '0, mk(4, 2, 1, 2, 2, 1'b0));
      // rerun; read address 48 in the cycle it is rewritten returns old word
      feed(71, 171); feed(72, 172);
      run(32'h0003_3002, 32'h0, -1, -1, 2, 7'd48, {32'd61, 32'd161},
          mk(4, 2, 1, 2, 2, 1'b0));
      rd_chk(7'd48, 71, 171);
      rd_chk(7'd49, 72, 172);
      step();
      step();

      chk("done_queue_drained", done_q.size(), 0);
      chk("rd_queue_drained", rd_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iq_sink.md
# iq_sink

Capture sink for the interpolator test/streaming path. It pops interpolated I/Q samples from the DUT's output FIFO with a read-enable/empty handshake and stores them in an internal dual-word memory. The memory is readable through a registered address port, and a status word is exported to the controlling bench or processor. It mirrors the Source block on the DUT input side and uses the same config/status register layout style.

## Interface
- DATA_WIDTH, 32, width of each I and Q sample
- MEM_SIZE_M, 7, memory address width; the capture memory holds 2**MEM_SIZE_M I/Q pairs

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle start pulse; honoured only in IDLE
- stop_i  in  1  ends continuous capture; ignored in other modes
- config_reg  in  32  [7:0] depth N, [15:8] offset, [17:16] mode; latched on accepted start
- empty_i  in  1  DUT output FIFO empty
- I_i, Q_i  in  DATA_WIDTH  FIFO read data, valid the cycle after RE_fifo_o
- RE_fifo_o  out  1  FIFO read enable
- rd_addr_i  in  MEM_SIZE_M  memory read address
- I_o, Q_o  out  DATA_WIDTH  registered memory read data
- status_reg  out  32  [0] busy, [1] done (sticky), [2] wrapped, [15:8] stored-sample count
- done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE -> CAPTURE on start_i.
  - Latch config.
  - Clear the done bit, wrapped bit, count and internal index.
  - Set busy.
- CAPTURE: RE_fifo_o = !empty_i && more reads are required. RE_fifo_o is never asserted while empty_i = 1.
- Each RE at cycle t yields a sample on I_i/Q_i at t+1. Track it with a one-deep valid pipeline flag.
- Modes:
  - 00 one-shot: exactly N reads and N stores.
  - 01 continuous: reads continue until stop_i. The store index wraps to 0 after N-1, and wrapped is set on the first wrap.
  - 10 decimate-by-2: 2N reads. Only the 1st, 3rd, 5th, … samples are stored, N stores in total.
  - 11: behaves as 00.
- Store address = (offset + index) mod 2**MEM_SIZE_M. Index counts stored samples from 0.
- count = stored samples, saturating at 255. In continuous mode it saturates and is not reset on wrap.
- Leaving CAPTURE:
  - CAPTURE -> DRAIN in the cycle the last required RE is issued, or when stop_i is sampled (mode 01). stop_i blocks RE in that cycle.
  - DRAIN holds until the in-flight sample is stored (one cycle).
  - DRAIN -> DONE: done_o = 1 for one cycle, done bit set, busy cleared. Then DONE -> IDLE.
- N = 0: CAPTURE issues no reads and proceeds to DRAIN -> DONE. In mode 01, N = 0 waits for stop_i without reading.
- start_i while busy: ignored, with no config relatch.
- Memory write and read of the same address in the same cycle: I_o/Q_o return the old contents.
- rst mid-capture: return to IDLE next edge and clear all outputs. Memory contents are undefined after reset (not cleared).

## Timing
- Reset values: RE_fifo_o = 0, done_o = 0, status_reg = 0, I_o = Q_o = 0, state IDLE.
- Start sampled at edge 0 → CAPTURE from cycle 1. The first RE can occur in cycle 1.
- One-shot, N samples, empty_i held 0:
  - RE high cycles 1..N
  - DRAIN cycle N+1, which stores the last sample
  - done_o high cycle N+2
  - IDLE cycle N+3
- Each empty_i = 1 cycle during CAPTURE delays completion by one cycle.
- Store latency: a sample read by RE in cycle t is written at the end of cycle t+1. It is readable by presenting rd_addr_i in cycle t+2, with data on I_o/Q_o in cycle t+3.
- Read port latency: 1 cycle, independent of state.

## Test plan
- Reset: hold rst for 3 cycles mid-traffic. All outputs are 0, and RE_fifo_o stays 0 with empty_i = 0.
- One-shot: N = 4, offset 0, empty_i = 0, FIFO I = 1..4, Q = 101..104.
  - RE high exactly cycles 1–4, done_o in cycle 6.
  - mem[0..3] = (1,101)…(4,104).
  - count = 4, status done = 1.
- Stall: same as the one-shot case, with empty_i = 1 on cycles 2 and 3.
  - RE is never high while empty, for exactly 4 reads.
  - done_o in cycle 8; memory contents identical.
- Wrap: MEM_SIZE_M = 7, offset 126, N = 4. Stores land at addresses 126, 127, 0, 1.
- Decimate: mode 10, N = 3, samples 10..15.
  - 6 RE pulses.
  - Memory holds 10, 12, 14; count = 3.
- Continuous: mode 01, N = 2.
  - Feed 5 samples, then stop_i. Memory = [5, 4], and wrapped = 1.
  - A start_i issued mid-run is ignored, and config_reg changes during the run have no effect.
